// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths,
// the writeback request record and the round-robin turn encoding.
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int REGW  = 5;
  localparam int NREGS = 1 << REGW;

  typedef struct packed {
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_e;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry writeback queue with occupancy count, full/empty flags and a
// per-slot valid mask so the parent can see every pending destination.
module wb_fifo #(
  parameter int DW    = 37,
  parameter int DEPTH = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_push,
  input  logic [DW-1:0]       i_din,
  input  logic                i_pop,
  output logic [DW-1:0]       o_head,
  output logic [DEPTH*DW-1:0] o_slots,
  output logic [DEPTH-1:0]    o_slot_vld,
  output logic                o_full,
  output logic                o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] w_vld_nxt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  // Overflow/underflow requests are ignored so a misbehaving parent cannot corrupt order
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rptr];
  assign o_slot_vld = r_vld;

  // Slot valid mask next state; push and pop never target the same slot
  always_comb begin
    w_vld_nxt           = r_vld;
    w_vld_nxt[r_rptr]   = r_vld[r_rptr] & ~w_pop;
    w_vld_nxt[r_wptr]   = w_vld_nxt[r_wptr] | w_push;
  end

  // Flatten storage for the parent's busy scan
  always_comb begin
    o_slots = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_slots[i*DW +: DW] = r_mem[i];
    end
  end

  // Queue storage, pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_vld <= w_vld_nxt;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU (A) and load (B) writeback streams into one register-file write
// port, with round-robin on contention, a pending-write bitmap and a conflict count.
module regfile_wb_arbiter #(
  parameter int XLEN  = regfile_pkg::XLEN,
  parameter int REGW  = regfile_pkg::REGW,
  parameter int DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_a_valid,
  output logic                 o_a_ready,
  input  logic [REGW-1:0]      i_a_rd,
  input  logic [XLEN-1:0]      i_a_data,
  input  logic                 i_b_valid,
  output logic                 o_b_ready,
  input  logic [REGW-1:0]      i_b_rd,
  input  logic [XLEN-1:0]      i_b_data,
  output logic                 o_rf_chip_en,
  output logic                 o_rf_write_en,
  output logic [REGW-1:0]      o_rf_wreg,
  output logic [XLEN-1:0]      o_rf_wdata,
  output logic [2**REGW-1:0]   o_busy,
  output logic [15:0]          o_conflict_cnt
);

  import regfile_pkg::*;

  localparam int DW = REGW + XLEN;
  localparam int NR = 1 << REGW;

  logic [DW-1:0]       w_a_head, w_b_head;
  logic [DEPTH*DW-1:0] w_a_slots, w_b_slots;
  logic [DEPTH-1:0]    w_a_vld, w_b_vld;
  logic                w_a_full, w_b_full, w_a_empty, w_b_empty;
  logic                w_a_push, w_b_push;
  logic                w_both, w_gnt_a, w_gnt_b;
  logic [NR-1:0]       w_busy;

  rr_e                 r_rr;
  logic                r_iss_vld;
  logic [REGW-1:0]     r_wreg;
  logic [XLEN-1:0]     r_wdata;
  logic [15:0]         r_conflict_cnt;

  // Ready is a function of start-of-cycle occupancy only, and is held low in reset
  assign o_a_ready = ~w_a_full & i_rst_n;
  assign o_b_ready = ~w_b_full & i_rst_n;
  // Writes to x0 complete the handshake but are dropped here
  assign w_a_push  = i_a_valid & o_a_ready & (i_a_rd != '0);
  assign w_b_push  = i_b_valid & o_b_ready & (i_b_rd != '0);

  wb_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_a (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_a_push),
    .i_din      ({i_a_rd, i_a_data}),
    .i_pop      (w_gnt_a),
    .o_head     (w_a_head),
    .o_slots    (w_a_slots),
    .o_slot_vld (w_a_vld),
    .o_full     (w_a_full),
    .o_empty    (w_a_empty)
  );

  wb_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_b (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_b_push),
    .i_din      ({i_b_rd, i_b_data}),
    .i_pop      (w_gnt_b),
    .o_head     (w_b_head),
    .o_slots    (w_b_slots),
    .o_slot_vld (w_b_vld),
    .o_full     (w_b_full),
    .o_empty    (w_b_empty)
  );

  // Grant selection: sole non-empty queue wins, otherwise the round-robin turn
  always_comb begin
    w_both  = ~w_a_empty & ~w_b_empty;
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (w_both) begin
      if (r_rr == RR_A) begin
        w_gnt_a = 1'b1;
      end else begin
        w_gnt_b = 1'b1;
      end
    end else if (!w_a_empty) begin
      w_gnt_a = 1'b1;
    end else if (!w_b_empty) begin
      w_gnt_b = 1'b1;
    end else begin
      w_gnt_a = 1'b0;
      w_gnt_b = 1'b0;
    end
  end

  // Pending-write bitmap over both queues and the issue register; x0 never busy
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_busy[w_a_slots[i*DW+XLEN +: REGW]] = w_busy[w_a_slots[i*DW+XLEN +: REGW]] | w_a_vld[i];
      w_busy[w_b_slots[i*DW+XLEN +: REGW]] = w_busy[w_b_slots[i*DW+XLEN +: REGW]] | w_b_vld[i];
    end
    w_busy[r_wreg] = w_busy[r_wreg] | r_iss_vld;
    w_busy[0]      = 1'b0;
  end

  // Issue register, round-robin turn and contention counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr           <= RR_A;
      r_iss_vld      <= 1'b0;
      r_wreg         <= '0;
      r_wdata        <= '0;
      r_conflict_cnt <= 16'h0000;
    end else begin
      if (w_gnt_a) begin
        r_iss_vld         <= 1'b1;
        {r_wreg, r_wdata} <= w_a_head;
      end else if (w_gnt_b) begin
        r_iss_vld         <= 1'b1;
        {r_wreg, r_wdata} <= w_b_head;
      end else begin
        r_iss_vld <= 1'b0;
      end
      if (w_both) begin
        r_rr <= (r_rr == RR_A) ? RR_B : RR_A;
        if (r_conflict_cnt != 16'hFFFF) begin
          r_conflict_cnt <= r_conflict_cnt + 16'h0001;
        end
      end
    end
  end

  assign o_rf_write_en  = r_iss_vld;
  assign o_rf_chip_en   = r_iss_vld;
  assign o_rf_wreg      = r_wreg;
  assign o_rf_wdata     = r_wdata;
  assign o_busy         = w_busy;
  assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a queue-based
// reference model of the writeback rules.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              a_valid = 1'b0, b_valid = 1'b0;
  logic [REGW-1:0]   a_rd = '0, b_rd = '0;
  logic [XLEN-1:0]   a_data = '0, b_data = '0;
  logic              a_ready, b_ready;
  logic              rf_chip_en, rf_write_en;
  logic [REGW-1:0]   rf_wreg;
  logic [XLEN-1:0]   rf_wdata;
  logic [NREGS-1:0]  busy;
  logic [15:0]       conflict_cnt;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(XLEN), .REGW(REGW), .DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_a_valid      (a_valid),
    .o_a_ready      (a_ready),
    .i_a_rd         (a_rd),
    .i_a_data       (a_data),
    .i_b_valid      (b_valid),
    .o_b_ready      (b_ready),
    .i_b_rd         (b_rd),
    .i_b_data       (b_data),
    .o_rf_chip_en   (rf_chip_en),
    .o_rf_write_en  (rf_write_en),
    .o_rf_wreg      (rf_wreg),
    .o_rf_wdata     (rf_wdata),
    .o_busy         (busy),
    .o_conflict_cnt (conflict_cnt)
  );

  // Reference model state
  wb_req_t         qa[$];
  wb_req_t         qb[$];
  bit              b_turn = 1'b0;
  bit              exp_we = 1'b0;
  logic [REGW-1:0] exp_rd = '0;
  logic [XLEN-1:0] exp_data = '0;
  int unsigned     exp_cnt = 0;
  logic [REGW-1:0] a_log[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREGS-1:0] model_busy();
    logic [NREGS-1:0] m;
    m = '0;
    foreach (qa[i]) m[qa[i].rd] = 1'b1;
    foreach (qb[i]) m[qb[i].rd] = 1'b1;
    if (exp_we) m[exp_rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic check_all();
    check("write_en", rf_write_en, exp_we);
    check("chip_en", rf_chip_en, exp_we);
    check("wreg", rf_wreg, exp_rd);
    check("wdata", rf_wdata, exp_data);
    check("busy", busy, model_busy());
    check("conflict_cnt", conflict_cnt, exp_cnt);
    check("a_ready", a_ready, qa.size() < DEPTH);
    check("b_ready", b_ready, qb.size() < DEPTH);
  endtask

  task automatic model_clear();
    qa.delete();
    qb.delete();
    b_turn   = 1'b0;
    exp_we   = 1'b0;
    exp_rd   = '0;
    exp_data = '0;
    exp_cnt  = 0;
  endtask

  // One clock: drive inputs, advance the model by the rules, check after the edge
  task automatic step(input bit av, input logic [REGW-1:0] ard, input logic [XLEN-1:0] ad,
                      input bit bv, input logic [REGW-1:0] brd, input logic [XLEN-1:0] bd);
    bit ar, br, pick_b;
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    ar = qa.size() < DEPTH;
    br = qb.size() < DEPTH;
    exp_we = 1'b0;
    if (qa.size() > 0 || qb.size() > 0) begin
      if (qa.size() > 0 && qb.size() > 0) begin
        if (exp_cnt < 32'hFFFF) exp_cnt++;
        pick_b = b_turn;
        b_turn = !b_turn;
      end else begin
        pick_b = (qa.size() == 0);
      end
      exp_we = 1'b1;
      if (pick_b) begin
        exp_rd = qb[0].rd; exp_data = qb[0].data; void'(qb.pop_front());
      end else begin
        exp_rd = qa[0].rd; exp_data = qa[0].data; void'(qa.pop_front());
      end
    end
    if (av && ar && ard != 0) qa.push_back(wb_req_t'{rd: ard, data: ad});
    if (bv && br && brd != 0) qb.push_back(wb_req_t'{rd: brd, data: bd});
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_ready"}, a_ready, 1'b0);
    check({tag, "_b_ready"}, b_ready, 1'b0);
    check({tag, "_write_en"}, rf_write_en, 1'b0);
    check({tag, "_chip_en"}, rf_chip_en, 1'b0);
    check({tag, "_wreg"}, rf_wreg, '0);
    check({tag, "_wdata"}, rf_wdata, '0);
    check({tag, "_busy"}, busy, '0);
    check({tag, "_cnt"}, conflict_cnt, 16'h0000);
  endtask

  initial begin
    int a_idx;
    bit saw_a_full;
    logic [REGW-1:0] r1, r2;

    // Reset state and first transfer right after release
    #2;
    check_reset_outputs("reset");
    #10;
    rst_n = 1'b1;
    #1;
    check("ready_after_release", a_ready, 1'b1);

    // A alone: rd 5
    step(1'b1, 5'd5, 32'h0000_0005, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b0, '0, '0);
    check("a_alone_we", rf_write_en, 1'b1);
    check("a_alone_wreg", rf_wreg, 5'd5);
    check("a_alone_wdata", rf_wdata, 32'h0000_0005);
    step(1'b0, '0, '0, 1'b0, '0, '0);
    check("a_alone_we_drop", rf_write_en, 1'b0);
    check("a_alone_busy5", busy[5], 1'b0);

    // Contention: A wins first, B next
    step(1'b1, 5'd3, 32'h0000_000A, 1'b1, 5'd4, 32'h0000_000B);
    step(1'b0, '0, '0, 1'b0, '0, '0);
    check("contend_first", rf_wreg, 5'd3);
    check("contend_cnt", conflict_cnt, 16'h0001);
    step(1'b0, '0, '0, 1'b0, '0, '0);
    check("contend_second", rf_wreg, 5'd4);
    idle(2);

    // Backpressure: A presents rd 1,2,3 held until accepted while B competes
    a_idx = 1;
    saw_a_full = 1'b0;
    a_log.delete();
    for (int c = 0; c < 16; c++) begin
      bit acc;
      if (!a_ready) saw_a_full = 1'b1;
      acc = (a_idx <= 3) && (qa.size() < DEPTH);
      step(a_idx <= 3, a_idx[REGW-1:0], 32'hA000_0000 | a_idx, 1'b1,
           REGW'(10 + c), 32'hB000_0000 | c);
      if (acc) a_idx++;
      if (rf_write_en && rf_wdata[31:28] == 4'hA) a_log.push_back(rf_wreg);
    end
    b_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, '0, '0, 1'b0, '0, '0);
      if (rf_write_en && rf_wdata[31:28] == 4'hA) a_log.push_back(rf_wreg);
    end
    check("bp_saw_full", saw_a_full, 1'b1);
    check("bp_count", a_log.size(), 3);
    for (int i = 0; i < 3 && i < a_log.size(); i++) check("bp_order", a_log[i], i + 1);

    // x0 writes are swallowed
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'hF0F0_F0F0);
    check("x0_busy", busy, '0);
    step(1'b0, '0, '0, 1'b0, '0, '0);
    check("x0_we", rf_write_en, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), REGW'($urandom_range(0, NREGS - 1)), $urandom,
           $urandom_range(0, 1), REGW'($urandom_range(0, NREGS - 1)), $urandom);
    end
    idle(4);

    // Reset mid-operation with three entries pending
    step(1'b1, 5'd7, 32'h7, 1'b1, 5'd8, 32'h8);
    step(1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'hA);
    r1 = 5'd0; r2 = 5'd0;
    check("pre_reset_pending", qa.size() + qb.size(), 3);
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    #2;
    check_reset_outputs("midreset");
    model_clear();
    @(posedge clk);
    #1;
    check_reset_outputs("midreset_hold");
    #2;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b0, '0, '0);
      check("post_reset_no_write", rf_write_en, 1'b0);
    end

    // Saturation: keep both queues occupied for more than 65535 cycles
    for (int i = 0; i < 70000; i++) begin
      step(1'b1, REGW'($urandom_range(1, NREGS - 1)), $urandom,
           1'b1, REGW'($urandom_range(1, NREGS - 1)), $urandom);
    end
    check("sat_value", conflict_cnt, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    end
    check("sat_hold", conflict_cnt, 16'hFFFF);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
